// File: rtl/hazard_unit_pkg.sv
// Shared pipeline types for the hazard unit.
// FSM state encoding and operand forwarding selects.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'b00,
        HZ_LDSTALL = 2'b01,
        HZ_MEMWAIT = 2'b10,
        HZ_BAD     = 2'b11
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/hazard_unit_forward_unit.sv
// Per-operand bypass select for the execute stage.
// The memory stage is younger than writeback, so it wins.
module forward_unit
    import hazard_unit_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic       reg_wr_m,
    input  logic [4:0] rd_w,
    input  logic       reg_wr_w,
    output logic [1:0] fwd
);

    // Pick the most recent in-flight producer of rs_e; x0 is never forwarded.
    always_comb begin
        fwd = FWD_RF;
        if (reg_wr_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            fwd = FWD_MEM;
        end else if (reg_wr_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: stalls, flushes, forwarding.
// Handles load-use bubbles, data-memory waits and taken branches.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic [4:0]  rs1_e,
    input  logic [4:0]  rs2_e,
    input  logic [4:0]  rd_e,
    input  logic        rd_en_e,
    input  logic        reg_wr_e,
    input  logic [4:0]  rd_m,
    input  logic        rd_en_m,
    input  logic        wr_en_m,
    input  logic        reg_wr_m,
    input  logic [4:0]  rd_w,
    input  logic        reg_wr_w,
    input  logic        br_taken_e,
    input  logic        dmem_ready,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        flush_d,
    output logic        flush_e,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [1:0]  hz_state,
    output logic [15:0] stall_cnt
);

    hz_state_e   state_q, state_d;
    logic        pend_q, pend_d;
    logic [15:0] cnt_q, cnt_d;

    logic        load_use, mem_busy;
    logic        sf, sd, se, sm, fd, fe;
    logic [1:0]  fa, fb;

    assign load_use = rd_en_e && reg_wr_e && (rd_e != 5'd0)
                      && ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign mem_busy = (rd_en_m || wr_en_m) && !dmem_ready;

    forward_unit u_fwd_a (
        .rs_e     (rs1_e),
        .rd_m     (rd_m),
        .reg_wr_m (reg_wr_m),
        .rd_w     (rd_w),
        .reg_wr_w (reg_wr_w),
        .fwd      (fa)
    );

    forward_unit u_fwd_b (
        .rs_e     (rs2_e),
        .rd_m     (rd_m),
        .reg_wr_m (reg_wr_m),
        .rd_w     (rd_w),
        .reg_wr_w (reg_wr_w),
        .fwd      (fb)
    );

    // Next state and raw controls; priority is mem wait, branch, load-use.
    always_comb begin
        state_d = HZ_RUN;
        pend_d  = 1'b0;
        sf      = 1'b0;
        sd      = 1'b0;
        se      = 1'b0;
        sm      = 1'b0;
        fd      = 1'b0;
        fe      = 1'b0;
        unique case (state_q)
            HZ_RUN, HZ_LDSTALL: begin
                if (mem_busy) begin
                    {sf, sd, se, sm} = 4'b1111;
                    pend_d  = pend_q || br_taken_e;
                    state_d = HZ_MEMWAIT;
                end else if (br_taken_e) begin
                    fd = 1'b1;
                    fe = 1'b1;
                end else if (load_use && (state_q == HZ_RUN)) begin
                    sf      = 1'b1;
                    sd      = 1'b1;
                    fe      = 1'b1;
                    state_d = HZ_LDSTALL;
                end
            end
            HZ_MEMWAIT: begin
                if (mem_busy) begin
                    {sf, sd, se, sm} = 4'b1111;
                    pend_d  = pend_q || br_taken_e;
                    state_d = HZ_MEMWAIT;
                end else if (pend_q || br_taken_e) begin
                    fd = 1'b1;
                    fe = 1'b1;
                end
            end
            default: begin
                state_d = HZ_RUN;
            end
        endcase
    end

    // Reset masks every control so the pipeline sees a quiet hazard unit.
    always_comb begin
        stall_f = sf && !rst;
        stall_d = sd && !rst;
        stall_e = se && !rst;
        stall_m = sm && !rst;
        flush_d = fd && !rst;
        flush_e = fe && !rst;
        fwd_a   = rst ? FWD_RF : fa;
        fwd_b   = rst ? FWD_RF : fb;
    end

    // Saturating count of fetch-stall cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_f && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // State, pending-flush and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HZ_RUN;
            pend_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz_state  = state_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit.
// Inputs change 1 time unit after posedge; outputs checked before next edge.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        rd_en_e, reg_wr_e, rd_en_m, wr_en_m, reg_wr_m, reg_wr_w;
    logic        br_taken_e, dmem_ready;
    logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
    logic [1:0]  fwd_a, fwd_b, hz_state;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk        (clk),
        .rst        (rst),
        .rs1_d      (rs1_d),
        .rs2_d      (rs2_d),
        .rs1_e      (rs1_e),
        .rs2_e      (rs2_e),
        .rd_e       (rd_e),
        .rd_en_e    (rd_en_e),
        .reg_wr_e   (reg_wr_e),
        .rd_m       (rd_m),
        .rd_en_m    (rd_en_m),
        .wr_en_m    (wr_en_m),
        .reg_wr_m   (reg_wr_m),
        .rd_w       (rd_w),
        .reg_wr_w   (reg_wr_w),
        .br_taken_e (br_taken_e),
        .dmem_ready (dmem_ready),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .stall_e    (stall_e),
        .stall_m    (stall_m),
        .flush_d    (flush_d),
        .flush_e    (flush_e),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .hz_state   (hz_state),
        .stall_cnt  (stall_cnt)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e}
    task automatic chk_ctl(input string tag, input logic [5:0] exp);
        chk(tag, {10'd0, stall_f, stall_d, stall_e, stall_m,
                  flush_d, flush_e}, {10'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0;
        rd_m = 0; rd_w = 0;
        rd_en_e = 0; reg_wr_e = 0; rd_en_m = 0; wr_en_m = 0;
        reg_wr_m = 0; reg_wr_w = 0; br_taken_e = 0; dmem_ready = 1;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        quiet();
        rst = 1;
        step();
        step();
        // Hazard-causing inputs while in reset: outputs must stay 0.
        rd_en_e = 1; reg_wr_e = 1; rd_e = 5; rs1_d = 5;
        rd_en_m = 1; dmem_ready = 0; br_taken_e = 1;
        reg_wr_m = 1; rd_m = 3; rs1_e = 3; rs2_e = 3;
        #3;
        chk_ctl("rst_ctl", 6'b000000);
        chk("rst_fwd", {12'd0, fwd_a, fwd_b}, 16'h0000);
        chk("rst_state", {14'd0, hz_state}, 16'd0);
        chk("rst_cnt", stall_cnt, 16'd0);
        step();
        chk("rst_cnt2", stall_cnt, 16'd0);
        do_reset();

        // Load-use: one bubble, then LDSTALL ignores the same hazard.
        rd_en_e = 1; reg_wr_e = 1; rd_e = 5; rs1_d = 5;
        #3;
        chk_ctl("lu_ctl", 6'b110001);
        chk("lu_state0", {14'd0, hz_state}, 16'd0);
        step();
        chk("lu_state1", {14'd0, hz_state}, 16'd1);
        chk_ctl("lu_ignored", 6'b000000);
        chk("lu_cnt1", stall_cnt, 16'd1);
        step();
        quiet();
        #3;
        chk("lu_state2", {14'd0, hz_state}, 16'd0);
        chk("lu_cnt2", stall_cnt, 16'd1);
        // x0 destination never causes a load-use stall.
        rd_en_e = 1; reg_wr_e = 1; rd_e = 0; rs2_d = 0;
        #1;
        chk_ctl("lu_x0", 6'b000000);
        // rs2 match also triggers.
        rd_e = 9; rs2_d = 9;
        #1;
        chk_ctl("lu_rs2", 6'b110001);
        // Branch outranks load-use.
        br_taken_e = 1;
        #1;
        chk_ctl("br_over_lu", 6'b000011);
        step();
        chk("br_state", {14'd0, hz_state}, 16'd0);
        do_reset();

        // Three-cycle memory wait.
        rd_en_m = 1; dmem_ready = 0;
        #3;
        chk_ctl("mw_c1", 6'b111100);
        chk("mw_s1", {14'd0, hz_state}, 16'd0);
        step();
        chk_ctl("mw_c2", 6'b111100);
        chk("mw_s2", {14'd0, hz_state}, 16'd2);
        step();
        chk_ctl("mw_c3", 6'b111100);
        step();
        dmem_ready = 1;
        #1;
        chk_ctl("mw_done", 6'b000000);
        chk("mw_cnt", stall_cnt, 16'd3);
        chk("mw_s3", {14'd0, hz_state}, 16'd2);
        step();
        chk("mw_run", {14'd0, hz_state}, 16'd0);
        do_reset();

        // Branch in the first cycle of a wait is deferred to the ready cycle.
        wr_en_m = 1; dmem_ready = 0; br_taken_e = 1;
        #3;
        chk_ctl("bw_c1", 6'b111100);
        step();
        br_taken_e = 0;
        #1;
        chk_ctl("bw_c2", 6'b111100);
        step();
        chk_ctl("bw_c3", 6'b111100);
        step();
        dmem_ready = 1;
        #1;
        chk_ctl("bw_ready", 6'b000011);
        step();
        wr_en_m = 0;
        #1;
        chk_ctl("bw_after", 6'b000000);
        chk("bw_state", {14'd0, hz_state}, 16'd0);

        // Forwarding: memory stage beats writeback; x0 and disabled writes ignored.
        rd_m = 3; reg_wr_m = 1; rd_w = 3; reg_wr_w = 1; rs1_e = 3; rs2_e = 4;
        #1;
        chk("fwd_mem", {14'd0, fwd_a}, 16'd1);
        chk("fwd_b_rf", {14'd0, fwd_b}, 16'd0);
        rd_m = 0; rs2_e = 3;
        #1;
        chk("fwd_wb", {14'd0, fwd_a}, 16'd2);
        chk("fwd_b_wb", {14'd0, fwd_b}, 16'd2);
        rd_m = 3; reg_wr_m = 0; rd_w = 0;
        #1;
        chk("fwd_none", {12'd0, fwd_a, fwd_b}, 16'd0);
        do_reset();

        // Reset during a wait drops the pending flush.
        rd_en_m = 1; dmem_ready = 0; br_taken_e = 1;
        step();
        br_taken_e = 0;
        #1;
        chk("rw_state", {14'd0, hz_state}, 16'd2);
        rst = 1;
        step();
        rst = 0;
        rd_en_m = 0; dmem_ready = 1;
        #1;
        chk("rw_run", {14'd0, hz_state}, 16'd0);
        chk("rw_cnt", stall_cnt, 16'd0);
        chk_ctl("rw_noflush", 6'b000000);
        step();
        chk_ctl("rw_noflush2", 6'b000000);

        // Counter saturation.
        rd_en_m = 1; dmem_ready = 0;
        for (int i = 0; i < 70000; i++) step();
        chk("sat_cnt", stall_cnt, 16'hFFFF);
        chk_ctl("sat_ctl", 6'b111100);
        step();
        chk("sat_hold", stall_cnt, 16'hFFFF);
        quiet();
        step();
        chk_ctl("sat_release", 6'b000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
